// File: rtl/shifter_pipe_if.sv
// Operand/result handshake bundle for shifter_pipe.
// master = producer/consumer side, slave = the shifter.
interface shifter_pipe_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_operandA;
  logic [SHW-1:0]   ctrl_shiftamt;
  logic [1:0]       ctrl_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_result;

  modport master (
    output in_valid,
    output data_operandA,
    output ctrl_shiftamt,
    output ctrl_op,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  data_result
  );

  modport slave (
    input  in_valid,
    input  data_operandA,
    input  ctrl_shiftamt,
    input  ctrl_op,
    input  out_ready,
    output in_ready,
    output out_valid,
    output data_result
  );
endinterface

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter: one log2 stage per register.
// Ops: 00 SLL, 01 SRL, 10 SRA, 11 ROR. Global stall on output.
module shifter_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic          clock,
  input  logic          reset,
  shifter_pipe_if.slave bus
);

  typedef struct packed {
    logic             vld;
    logic [1:0]       op;
    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] data;
  } stg_t;

  stg_t cur     [SHW];
  stg_t stage_d [SHW];
  stg_t stage_q [SHW];
  logic en;

  // SRA fills with the current MSB, which every SRA stage
  // preserves, so the captured operand sign is carried along.
  function automatic logic [WIDTH-1:0] shift_by(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       op,
    input int unsigned      sh
  );
    logic [WIDTH-1:0] r;
    case (op)
      2'b00:   r = d << sh;
      2'b01:   r = d >> sh;
      2'b10:   r = WIDTH'($signed(d) >>> sh);
      default: r = (d >> sh) | (d << (WIDTH - sh));
    endcase
    return r;
  endfunction

  assign en            = !(stage_q[SHW-1].vld && !bus.out_ready);
  assign bus.in_ready  = en;
  assign bus.out_valid = stage_q[SHW-1].vld;
  assign bus.data_result = stage_q[SHW-1].data;

  // Source of each stage: inputs for stage 0, else predecessor.
  always_comb begin
    cur[0] = '{
      vld:  bus.in_valid,
      op:   bus.ctrl_op,
      amt:  bus.ctrl_shiftamt,
      data: bus.data_operandA
    };
    for (int k = 1; k < SHW; k++) begin
      cur[k] = stage_q[k-1];
    end
  end

  // Stage k shifts by 2^k when its amount bit is set.
  always_comb begin
    for (int k = 0; k < SHW; k++) begin
      stage_d[k] = cur[k];
      if (cur[k].amt[k]) begin
        stage_d[k].data = shift_by(
          cur[k].data, cur[k].op, 1 << k);
      end
    end
  end

  // Stage registers: clear on reset, advance only when en.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < SHW; k++) begin
        stage_q[k] <= '0;
      end
    end else if (en) begin
      for (int k = 0; k < SHW; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

endmodule

// File: tb/tb_shifter_pipe.sv
// Scoreboard bench for shifter_pipe (WIDTH=32, latency 5).
// Driver pushes expected results; monitor pops on transfer.
module tb_shifter_pipe;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rnd_done = 1'b0;

  typedef struct {
    logic [31:0] exp;
    int          acc;
    bit          lat;
    string       name;
  } exp_t;

  exp_t sb[$];

  shifter_pipe_if #(.WIDTH(32), .SHW(5)) bus ();

  shifter_pipe #(.WIDTH(32), .SHW(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] req
  );
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] model(
    input logic [1:0]  op,
    input logic [31:0] a,
    input int          s
  );
    logic [63:0] w;
    case (op)
      2'd0: return a << s;
      2'd1: return a >> s;
      2'd2: return 32'($signed(a) >>> s);
      default: begin
        w = {a, a};
        return w[s +: 32];
      end
    endcase
  endfunction

  // Monitor: every output transfer must match the queue head.
  always @(negedge clock) begin : mon
    exp_t e;
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h required none",
                 bus.data_result);
      end else begin
        e = sb.pop_front();
        chk(e.name, bus.data_result, e.exp);
        if (e.lat) chk({e.name, "_lat"}, 32'(cyc - e.acc), 32'd5);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(
    input string       nm,
    input logic [1:0]  op,
    input logic [31:0] a,
    input logic [4:0]  s,
    input logic [31:0] exp,
    input bit          lat
  );
    int   t;
    exp_t e;
    bus.in_valid      = 1'b1;
    bus.ctrl_op       = op;
    bus.data_operandA = a;
    bus.ctrl_shiftamt = s;
    t = 0;
    @(negedge clock);
    while (!bus.in_ready && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout %s: in_ready 0 required 1", nm);
    end else begin
      e = '{exp, cyc, lat, nm};
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
  endtask

  logic [31:0] ror_exp [8] = '{
    32'h12345678, 32'h091A2B3C, 32'h048D159E, 32'h02468ACF,
    32'h81234567, 32'hC091A2B3, 32'hE048D159, 32'hF02468AC
  };

  initial begin : main
    logic [31:0] hold;
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  s;
    int          t;
    bus.in_valid      = 1'b0;
    bus.ctrl_op       = 2'd0;
    bus.data_operandA = '0;
    bus.ctrl_shiftamt = '0;
    bus.out_ready     = 1'b1;
    reset             = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_data", bus.data_result, 32'd0);
    reset = 1'b0;

    send("sra_basic", 2'd2, 32'h80000000, 5'd4, 32'hF8000000, 1);
    send("srl_basic", 2'd1, 32'h80000000, 5'd4, 32'h08000000, 1);
    send("sll_basic", 2'd0, 32'h00000001, 5'd31, 32'h80000000, 1);
    send("ror_basic", 2'd3, 32'h00000001, 5'd1, 32'h80000000, 1);
    send("sra_pos31", 2'd2, 32'h7FFFFFFF, 5'd31, 32'h00000000, 1);
    send("sra_neg31", 2'd2, 32'h80000001, 5'd31, 32'hFFFFFFFF, 1);
    for (int i = 0; i < 4; i++) begin
      send("shift0", 2'(i), 32'hA5A5A5A5, 5'd0, 32'hA5A5A5A5, 1);
    end
    idle(8);

    for (int i = 0; i < 8; i++) begin
      send("ror_tput", 2'd3, 32'h12345678, 5'(i), ror_exp[i], 1);
    end
    idle(8);

    bus.out_ready = 1'b0;
    send("bp0", 2'd0, 32'h0000000F, 5'd4, 32'h000000F0, 0);
    send("bp1", 2'd1, 32'h000000F0, 5'd4, 32'h0000000F, 0);
    send("bp2", 2'd2, 32'h80000000, 5'd1, 32'hC0000000, 0);
    send("bp3", 2'd3, 32'h0000000F, 5'd4, 32'hF0000000, 0);
    send("bp4", 2'd0, 32'h00000001, 5'd16, 32'h00010000, 0);
    @(negedge clock);
    chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    hold = bus.data_result;
    repeat (2) begin
      @(negedge clock);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_stable", bus.data_result, hold);
    end
    @(posedge clock);
    #1;
    bus.out_ready = 1'b1;
    idle(10);
    chk("bp_drained", 32'(sb.size()), 32'd0);

    send("mid0", 2'd0, 32'h00000003, 5'd2, 32'h0000000C, 0);
    send("mid1", 2'd1, 32'hFFFF0000, 5'd8, 32'h00FFFF00, 0);
    send("mid2", 2'd3, 32'h0000FFFF, 5'd8, 32'hFF0000FF, 0);
    reset = 1'b1;
    bus.in_valid      = 1'b1;
    bus.ctrl_op       = 2'd0;
    bus.data_operandA = 32'hDEADBEEF;
    bus.ctrl_shiftamt = 5'd0;
    sb.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    chk("mid_rst_data", bus.data_result, 32'd0);
    repeat (6) begin
      @(negedge clock);
      chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_in_ready", 32'(bus.in_ready), 32'd1);
    end
    @(posedge clock);
    #1;

    fork
      begin
        while (!rnd_done) begin
          @(posedge clock);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      s  = 5'($urandom_range(0, 31));
      send("rnd", op, a, s, model(op, a, int'(s)), 0);
    end
    rnd_done = 1'b1;
    idle(2);
    bus.out_ready = 1'b1;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      idle(1);
      t++;
    end
    chk("rnd_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/shifter_pipe.md
SHIFTER_PIPE -- requirements
Module: shifter_pipe

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; SHALL be a power of two, 8 to 64 inclusive.
REQ-002 Parameter SHW, default 5, shift-amount width; SHALL equal log2(WIDTH).
REQ-003 Port clock, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1, reset; synchronous and active-high.
REQ-005 Port in_valid, input, 1, the input operand set is valid this cycle.
REQ-006 Port in_ready, output, 1, the block accepts the input operand set this cycle.
REQ-007 Port data_operandA, input, WIDTH, operand to be shifted.
REQ-008 Port ctrl_shiftamt, input, SHW, shift distance, 0 to WIDTH-1.
REQ-009 Port ctrl_op, input, 2, operation select: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-010 Port out_valid, output, 1, data_result holds a completed result.
REQ-011 Port out_ready, input, 1, the consumer accepts the result this cycle.
REQ-012 Port data_result, output, WIDTH, shifted result.

Function
REQ-013 An input transfer SHALL occur in a cycle where in_valid=1 and in_ready=1; an output transfer SHALL occur where out_valid=1 and out_ready=1.
REQ-014 The datapath SHALL have SHW registered stages; stage k (k=0..SHW-1) shifts by 2^k when shiftamt bit k=1 and passes the value through unchanged otherwise.
REQ-015 Each stage register SHALL carry its data word, valid bit, ctrl_op and the remaining shift-amount bits.
REQ-016 SLL: zeros fill vacated LSBs; SRL: zeros fill vacated MSBs.
REQ-017 SRA: data_operandA[WIDTH-1] as captured at input SHALL fill vacated MSBs; the result MSB always equals the operand MSB.
REQ-018 ROR: bits shifted out at the LSB end SHALL re-enter at the MSB end; no bit is lost.
REQ-019 ctrl_shiftamt=0 SHALL return data_operandA unchanged for all four ops.
REQ-020 Latency: an operand accepted in cycle N SHALL present on data_result with out_valid=1 in cycle N+SHW when no stall occurs.
REQ-021 Global advance enable en = NOT(out_valid AND NOT out_ready); in_ready SHALL equal en, driven combinationally.
REQ-022 en=1: every stage SHALL load from its predecessor; stage 0 SHALL load the inputs with valid = in_valid.
REQ-023 en=0 (stall): every stage register SHALL hold data, valid and control; no input SHALL be accepted and no result SHALL be lost or duplicated.
REQ-024 Throughput: one result per cycle SHALL be sustained while in_valid=1 and out_ready=1.
REQ-025 Bubbles (in_valid=0 with en=1) SHALL propagate as valid=0 stages; out_valid SHALL be the last stage's valid bit.
REQ-026 data_result SHALL be driven directly from the last stage register, with no combinational path from any input.
REQ-027 Results SHALL leave in acceptance order; the pipeline SHALL never reorder.
REQ-028 Inputs with in_valid=0 SHALL NOT alter any valid bit.

Reset
REQ-029 With reset=1 at a clock edge, all stage valid bits SHALL clear to 0.
REQ-030 After that edge, out_valid SHALL be 0 and in_ready SHALL be 1.
REQ-031 Stage data registers SHALL clear to 0, so data_result=0 after reset.
REQ-032 Reset mid-operation SHALL discard every in-flight operand; none SHALL appear at the output afterwards.
REQ-033 Reset SHALL take priority over en and in_valid in the same cycle.
REQ-034 The first input SHALL be accepted in the first cycle after reset is deasserted.

Verification (WIDTH=32, SHW=5, latency 5)
REQ-035 Basic ops: apply the following, each with out_ready=1:
- SRA 0x80000000 by 4 -> 0xF8000000, out_valid 5 cycles later.
- SRL 0x80000000 by 4 -> 0x08000000.
- SLL 0x00000001 by 31 -> 0x80000000.
- ROR 0x00000001 by 1 -> 0x80000000.
REQ-036 Edges: apply the following:
- SRA 0x7FFFFFFF by 31 -> 0x00000000.
- SRA 0x80000001 by 31 -> 0xFFFFFFFF.
- Any op with shift 0 on 0xA5A5A5A5 -> 0xA5A5A5A5.
REQ-037 Throughput: send 8 back-to-back ROR operations by 0..7 on 0x12345678 with out_ready=1 -> 8 consecutive out_valid cycles starting at cycle 5, in order; the by-4 result = 0x81234567.
REQ-038 Backpressure: fill the pipe, then hold out_ready=0 for 3 cycles. Required response:
- in_ready=0 throughout.
- data_result stable.
- On release, all results are delivered exactly once, in order.
REQ-039 Reset mid-flight: accept 3 operands, assert reset for 1 cycle at cycle 2 -> out_valid stays 0 for 6 cycles, in_ready=1, and no stale result appears.
REQ-040 Random: 10k random ops, shifts, operands and out_ready/in_valid patterns, compared against a reference model -> zero mismatches, zero lost or duplicated results.
